// File: rtl/ssi_encoder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ssi_encoder_ctrl
// Purpose  : Runs one read of an SSI absolute encoder. It drives the SSI
//            clock, shifts in DATA_BITS Gray-coded bits MSB first, then holds
//            the clock high for the encoder monoflop time. The assembled Gray
//            word is presented with a one-cycle read strobe for a downstream
//            Gray-to-binary converter. Reads start on request (start) or
//            periodically (auto_en, every POLL_CYCLES clk cycles).
// Ports    : clk       system clock
//            rst       synchronous reset, active high
//            start     read request (level or pulse), sampled only when idle
//            auto_en   enables periodic reads
//            ssi_data  encoder data line, already synchronised, idles high
//            ssi_clk   SSI clock to the encoder, idles high
//            gray_out  captured Gray word in [DATA_BITS-1:0], upper bits 0
//            read_out  one-cycle strobe, gray_out valid in the same cycle
//            busy      high while a transaction is in progress
//            line_err  one-cycle pulse: request refused, data line low
// Revision : 1.0  initial release
// ============================================================================
module ssi_encoder_ctrl #(
    parameter int DATA_BITS   = 25,
    parameter int CLK_DIV     = 25,
    parameter int MONO_CYCLES = 1250,
    parameter int POLL_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        auto_en,
    input  logic        ssi_data,
    output logic        ssi_clk,
    output logic [31:0] gray_out,
    output logic        read_out,
    output logic        busy,
    output logic        line_err
);

    localparam int c_BIT_W  = (DATA_BITS > 1)   ? $clog2(DATA_BITS)   : 1;
    localparam int c_DIV_W  = $clog2(2 * CLK_DIV);
    localparam int c_MONO_W = (MONO_CYCLES > 1) ? $clog2(MONO_CYCLES) : 1;
    localparam int c_POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [c_BIT_W-1:0]  c_BIT_TOP   = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_HALF  = c_DIV_W'(CLK_DIV);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(2 * CLK_DIV - 1);
    localparam logic [c_MONO_W-1:0] c_MONO_LAST = c_MONO_W'(MONO_CYCLES - 1);
    localparam logic [c_POLL_W-1:0] c_POLL_LAST = c_POLL_W'(POLL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MONO  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_DIV_W-1:0]     r_div_cnt;
    logic [c_DIV_W-1:0]     w_div_next;
    logic [c_BIT_W-1:0]     r_bit_cnt;
    logic [c_BIT_W-1:0]     w_bit_next;
    logic [c_MONO_W-1:0]    r_mono_cnt;
    logic [c_MONO_W-1:0]    w_mono_next;
    logic [c_POLL_W-1:0]    r_poll_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic [31:0]            r_gray;
    logic                   r_ssi_clk;
    logic                   w_ssi_clk_next;
    logic                   r_read;
    logic                   w_read_next;
    logic                   r_line_err;
    logic                   w_line_err_next;
    logic                   w_poll_tick;
    logic                   w_request;

    // Poll timer: free-running while auto_en is high, held at 0 otherwise.
    // A tick that lands while busy is simply lost.
    assign w_poll_tick = auto_en && (r_poll_cnt == c_POLL_LAST);
    assign w_request   = start || w_poll_tick;

    always_ff @(posedge clk) begin
        if (rst || !auto_en || w_poll_tick) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= r_poll_cnt + c_POLL_W'(1);
        end
    end

    // Next-state logic. In SHIFT, r_div_cnt walks through one bit period:
    // 0..CLK_DIV-1 is the low half, CLK_DIV..2*CLK_DIV-1 the high half.
    always_comb begin
        w_state_next    = r_state;
        w_div_next      = r_div_cnt;
        w_bit_next      = r_bit_cnt;
        w_mono_next     = r_mono_cnt;
        w_shift_next    = r_shift;
        w_read_next     = 1'b0;
        w_line_err_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_request) begin
                    if (ssi_data) begin
                        w_state_next = ST_SHIFT;
                        w_bit_next   = c_BIT_TOP;
                        w_div_next   = '0;
                    end else begin
                        w_line_err_next = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                // First cycle of the high half: the encoder has had the whole
                // low half to settle its bit.
                if (r_div_cnt == c_DIV_HALF) begin
                    w_shift_next[r_bit_cnt] = ssi_data;
                end
                if (r_div_cnt == c_DIV_LAST) begin
                    w_div_next = '0;
                    if (r_bit_cnt == '0) begin
                        w_state_next = ST_MONO;
                        w_mono_next  = '0;
                        w_read_next  = 1'b1;
                    end else begin
                        w_bit_next = r_bit_cnt - c_BIT_W'(1);
                    end
                end else begin
                    w_div_next = r_div_cnt + c_DIV_W'(1);
                end
            end
            ST_MONO: begin
                if (r_mono_cnt == c_MONO_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_mono_next = r_mono_cnt + c_MONO_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // ssi_clk is registered from the next state so the encoder sees a
        // glitch-free clock; it is low only during the low half of a bit.
        w_ssi_clk_next = !((w_state_next == ST_SHIFT) && (w_div_next < c_DIV_HALF));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_mono_cnt <= '0;
            r_shift    <= '0;
            r_gray     <= '0;
            r_ssi_clk  <= 1'b1;
            r_read     <= 1'b0;
            r_line_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_div_cnt  <= w_div_next;
            r_bit_cnt  <= w_bit_next;
            r_mono_cnt <= w_mono_next;
            r_shift    <= w_shift_next;
            r_ssi_clk  <= w_ssi_clk_next;
            r_read     <= w_read_next;
            r_line_err <= w_line_err_next;
            // Capture from the next-value shift word so bit 0 is included even
            // when its sample and the end of the frame share a cycle.
            if (w_read_next) begin
                r_gray <= 32'(w_shift_next);
            end
        end
    end

    assign ssi_clk  = r_ssi_clk;
    assign gray_out = r_gray;
    assign read_out = r_read;
    assign line_err = r_line_err;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ssi_encoder_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ssi_encoder_ctrl
// Purpose  : Bench for ssi_encoder_ctrl with an SSI encoder model, a
//            cycle-offset reference model and directed scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_ssi_encoder_ctrl;

    localparam int DB   = 25;
    localparam int CD   = 25;
    localparam int MONO = 1250;
    localparam int POLL = 3000;
    localparam int S    = 2 * CD * DB;   // cycles of clocking
    localparam int T    = S + MONO;      // cycles busy per transaction

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        auto_en;
    logic        line_low;
    wire         ssi_data;
    logic        ssi_clk;
    logic [31:0] gray_out;
    logic        read_out;
    logic        busy;
    logic        line_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ssi_encoder_ctrl #(
        .DATA_BITS  (DB),
        .CLK_DIV    (CD),
        .MONO_CYCLES(MONO),
        .POLL_CYCLES(POLL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .auto_en (auto_en),
        .ssi_data(ssi_data),
        .ssi_clk (ssi_clk),
        .gray_out(gray_out),
        .read_out(read_out),
        .busy    (busy),
        .line_err(line_err)
    );

    // ---------------- encoder model: new bit on each falling ssi_clk --------
    logic [31:0] enc_word = 32'd0;
    logic        enc_bit  = 1'b1;
    int          enc_idx  = DB - 1;
    int          fall_cnt = 0;

    assign ssi_data = line_low ? 1'b0 : enc_bit;

    always @(negedge ssi_clk or posedge read_out or posedge rst) begin
        if (rst || read_out) begin
            enc_idx = DB - 1;
            enc_bit = 1'b1;
        end else begin
            fall_cnt = fall_cnt + 1;
            if (enc_idx >= 0) begin
                enc_bit = enc_word[enc_idx];
                enc_idx = enc_idx - 1;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ------------------
    bit          m_valid = 1'b0;
    bit          m_trans = 1'b0;
    int          m_acc   = 0;
    int          m_origin = 0;
    logic [31:0] m_word  = 32'd0;
    logic [31:0] m_gray  = 32'd0;
    logic        m_err_pend = 1'b0;
    logic [31:0] c_mask  = (32'd1 << DB) - 32'd1;
    int          k;
    logic        e_busy, e_sclk, e_read, e_tick, e_req;

    always @(negedge clk) begin
        e_busy = 1'b0;
        if (m_valid) begin
            k      = cyc - m_acc;
            e_busy = m_trans && (k >= 1) && (k <= T);
            e_sclk = !(m_trans && (k >= 1) && (k <= S) && (((k - 1) % (2 * CD)) < CD));
            e_read = m_trans && (k == S + 1);
            if (e_read) m_gray = m_word;
            total = total + 1;
            if ({ssi_clk, busy, read_out, line_err, gray_out} !==
                {e_sclk, e_busy, e_read, m_err_pend, m_gray}) begin
                bad = bad + 1;
                $display("FAIL cycle %0d: got sclk=%b busy=%b read=%b err=%b gray=%h, expected sclk=%b busy=%b read=%b err=%b gray=%h",
                         cyc, ssi_clk, busy, read_out, line_err, gray_out,
                         e_sclk, e_busy, e_read, m_err_pend, m_gray);
            end
        end
        if (rst) begin
            m_valid    = 1'b1;
            m_trans    = 1'b0;
            m_gray     = 32'd0;
            m_err_pend = 1'b0;
            m_origin   = cyc + 1;
        end else if (m_valid) begin
            e_tick = auto_en && (((cyc - m_origin) % POLL) == POLL - 1);
            if (!auto_en) m_origin = cyc + 1;
            e_req      = start || e_tick;
            m_err_pend = !e_busy && e_req && !ssi_data;
            if (!e_busy && e_req && ssi_data) begin
                m_trans = 1'b1;
                m_acc   = cyc;
                m_word  = enc_word & c_mask;
            end
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_read(input int limit, output int at);
        at = -100000;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (read_out === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int limit, output int at);
        at = -100000;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic count_reads(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (read_out === 1'b1) cnt = cnt + 1;
        end
    endtask

    function automatic logic [31:0] g2b(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
        return b;
    endfunction

    // ---------------- directed scenarios -----------------------------------
    initial begin
        int n, r, r1, r2, idl, f0, cnt, x;
        rst = 1'b1; start = 1'b0; auto_en = 1'b0; line_low = 1'b0;
        step(3);
        @(negedge clk);
        chk("reset ssi_clk",  {31'd0, ssi_clk},  32'd1);
        chk("reset busy",     {31'd0, busy},     32'd0);
        chk("reset gray_out", gray_out,          32'd0);
        chk("reset read_out", {31'd0, read_out}, 32'd0);
        chk("reset line_err", {31'd0, line_err}, 32'd0);
        step(1); rst = 1'b0;
        step(2);

        // 1) single read of Gray 25'h1A5A5A5
        enc_word = 32'h01A5A5A5;
        f0 = fall_cnt;
        start = 1'b1; n = cyc;
        step(1); start = 1'b0;
        wait_read(1400, r);
        chk("t1 read latency", r - n, 32'd1251);
        chk("t1 gray_out", gray_out, 32'h01A5A5A5);
        chk("t1 ssi_clk falls", fall_cnt - f0, 32'd25);
        wait_idle(1400, idl);
        chk("t1 busy release", idl - r, 32'd1250);

        // 2) position 12345 in Gray, converted back
        step(1);
        enc_word = 32'd12345 ^ (32'd12345 >> 1);
        start = 1'b1;
        step(1); start = 1'b0;
        wait_read(1400, r);
        chk("t2 gray_out", gray_out, 32'h00002825);
        chk("t2 converted", g2b(gray_out), 32'd12345);
        wait_idle(1400, idl);

        // 3) periodic reads, start while busy is dropped
        step(1); auto_en = 1'b1; x = cyc;
        wait_read(5000, r1);
        chk("t3 first poll read", r1 - x, 32'd4250);
        step(100); start = 1'b1;
        step(1); start = 1'b0;
        wait_read(3500, r2);
        chk("t3 poll period", r2 - r1, 32'd3000);
        step(1); auto_en = 1'b0;
        wait_idle(3000, idl);

        // 4) data line low in IDLE
        step(1); line_low = 1'b1; start = 1'b1;
        step(1); line_low = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("t4 line_err", {31'd0, line_err}, 32'd1);
        chk("t4 busy", {31'd0, busy}, 32'd0);
        chk("t4 ssi_clk", {31'd0, ssi_clk}, 32'd1);
        count_reads(100, cnt);
        chk("t4 no read", cnt, 32'd0);

        // 5) reset midway through bit 10
        step(1); start = 1'b1;
        step(1); start = 1'b0;
        step(724); rst = 1'b1;
        @(negedge clk);
        chk("t5 gray held", gray_out, 32'h00002825);
        chk("t5 busy before rst", {31'd0, busy}, 32'd1);
        step(1); rst = 1'b0;
        @(negedge clk);
        chk("t5 ssi_clk after rst", {31'd0, ssi_clk}, 32'd1);
        chk("t5 busy after rst", {31'd0, busy}, 32'd0);
        chk("t5 gray after rst", gray_out, 32'd0);
        count_reads(2600, cnt);
        chk("t5 no read", cnt, 32'd0);

        // 6) start held high -> back-to-back reads
        step(1); start = 1'b1; n = cyc;
        wait_read(1400, r1);
        chk("t6 first latency", r1 - n, 32'd1251);
        wait_read(2600, r2);
        chk("t6 back-to-back", r2 - r1, 32'd2501);
        step(1); start = 1'b0;
        wait_idle(1400, idl);

        // 6b) start coincident with poll tick -> one transaction
        step(1); auto_en = 1'b1; x = cyc;
        step(2999); start = 1'b1;
        step(1); start = 1'b0; auto_en = 1'b0;
        wait_read(1400, r);
        chk("t6 coincident latency", r - x, 32'd4250);
        count_reads(2600, cnt);
        chk("t6 single transaction", cnt, 32'd0);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
